mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RISC-V M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at configurable width.
- Sits beside the combinational integer ALU in the execute stage. Takes multi-cycle M-ops via valid/ready handshakes, so the pipeline stalls only while the unit is busy.
- Computes with radix-2 shift-add multiply and restoring divide on operand magnitudes, then applies a sign fix-up.

---
 rtl/mdu_iter.sv | 142 ++++++++++++++
 tb/tb_mdu_iter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit: radix-2 shift-add multiply,
// restoring divide on operand magnitudes, sign fix-up in a final cycle.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q;
    logic [2:0]          op_q;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q;
    logic                neg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     result_q, result_d;
    logic                out_valid_q;

    logic                a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div0, ovf;
    logic [XLEN-1:0]     special_res;
    logic [XLEN:0]       mul_sum, div_rem, div_trial;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;

    // Operand decode and special-case detection for the accept cycle.
    always_comb begin
        a_signed    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa          = a_signed && a[XLEN-1];
        sb          = b_signed && b[XLEN-1];
        mag_a       = sa ? -a : a;
        mag_b       = sb ? -b : b;
        div0        = op[2] && (b == '0);
        ovf         = ((op == 3'b100) || (op == 3'b110)) && (a == MOST_NEG) && (b == '1);
        special_res = '0;
        if (div0)
            special_res = op[1] ? a : '1;
        else if (ovf)
            special_res = op[1] ? '0 : MOST_NEG;
    end

    // One iteration: multiply keeps product-high:multiplier, divide keeps remainder:dividend/quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_rem   = acc_q[2*XLEN-1:XLEN-1];
        div_trial = div_rem - {1'b0, opb_q};
        if (op_q[2]) begin
            if (div_trial[XLEN])
                acc_d = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            else
                acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = quo_fix;
            default:                result_d = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        if (div0 || ovf) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
                            opb_q   <= op[2] ? mag_b : mag_a;
                            neg_q   <= (op[2] && op[1]) ? sa : (sa ^ sb);
                            cnt_q   <= CNT_W'(XLEN);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state_q <= FIX;
                end
                FIX: begin
                    result_q    <= result_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter at XLEN=32 and XLEN=8 with hand-computed results.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, result32;
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, result8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid32), .in_ready(in_ready32), .op(op32), .a(a32), .b(b32),
        .out_valid(out_valid32), .out_ready(out_ready32), .result(result32)
    );

    mdu_iter #(.XLEN(8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept one op on the 32-bit unit, measure latency, check result and the return to idle.
    task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        op32 = o; a32 = x; b32 = y; in_valid32 = 1'b1; out_ready32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        lat = 1;
        while (!out_valid32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check(tag, 64'(result32), 64'(exp));
        check({tag, "_busy"}, 64'(in_ready32), 64'd0);
        @(posedge clk); #1;
        check({tag, "_vdrop"}, 64'(out_valid32), 64'd0);
        check({tag, "_rdy"}, 64'(in_ready32), 64'd1);
    endtask

    task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check(tag, 64'(result8), 64'(exp));
        @(posedge clk); #1;
        check({tag, "_rdy"}, 64'(in_ready8), 64'd1);
    endtask

    initial begin
        int seen;
        logic [31:0] held;
        rst = 1'b1; flush = 1'b0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; op32 = '0; a32 = '0; b32 = '0;
        in_valid8 = 1'b0;  out_ready8 = 1'b1;  op8 = '0;  a8 = '0;  b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inready", 64'(in_ready32), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_inready_rel", 64'(in_ready32), 64'd1);
        check("rst_outvalid", 64'(out_valid32), 64'd0);
        check("rst_result", 64'(result32), 64'd0);
        check("rst_result8", 64'(result8), 64'd0);

        run32("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run32("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run32("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run32("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);

        run32("div",    3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run32("rem",    3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run32("divu",   3'b101, 32'd100,      32'd7, 32'd14,       34);
        run32("remu",   3'b111, 32'd100,      32'd7, 32'd2,        34);

        run32("divu_z", 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run32("rem_z",  3'b110, 32'd5,        32'd0,        32'd5,        1);
        run32("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run32("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Backpressure: hold the result for 5 cycles.
        @(negedge clk);
        op32 = 3'b101; a32 = 32'd100; b32 = 32'd7; in_valid32 = 1'b1; out_ready32 = 1'b0;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        seen = 0;
        while (!out_valid32 && seen < 200) begin
            @(posedge clk); #1;
            seen++;
        end
        check("bp_valid", 64'(out_valid32), 64'd1);
        held = result32;
        check("bp_value", 64'(held), 64'd14);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_v", 64'(out_valid32), 64'd1);
            check("bp_hold_r", 64'(result32), 64'(held));
            check("bp_hold_rdy", 64'(in_ready32), 64'd0);
        end
        out_ready32 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_v", 64'(out_valid32), 64'd0);
        check("bp_release_rdy", 64'(in_ready32), 64'd1);

        // Flush mid-divide.
        @(negedge clk);
        op32 = 3'b100; a32 = 32'd1000; b32 = 32'd3; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_rdy", 64'(in_ready32), 64'd1);
        check("flush_v", 64'(out_valid32), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid32) seen = 1;
        end
        check("flush_no_out", 64'(seen), 64'd0);

        // Reset mid-divide.
        @(negedge clk);
        op32 = 3'b100; a32 = 32'd1000; b32 = 32'd3; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rstmid_rdy", 64'(in_ready32), 64'd1);
        check("rstmid_v", 64'(out_valid32), 64'd0);
        check("rstmid_res", 64'(result32), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid32) seen = 1;
        end
        check("rstmid_no_out", 64'(seen), 64'd0);

        // Flush coincident with a request: nothing is accepted.
        @(negedge clk);
        op32 = 3'b101; a32 = 32'd5; b32 = 32'd0; in_valid32 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0; flush = 1'b0;
        check("flushreq_rdy", 64'(in_ready32), 64'd1);
        check("flushreq_v", 64'(out_valid32), 64'd0);
        @(posedge clk); #1;
        check("flushreq_v2", 64'(out_valid32), 64'd0);

        run8("mul8",  3'b000, 8'h0F, 8'h11, 8'hFF, 10);
        run8("div8o", 3'b100, 8'h80, 8'hFF, 8'h80, 1);
        run8("div8",  3'b100, 8'h81, 8'h03, 8'hD6, 10);
        run8("rem8",  3'b110, 8'h81, 8'h03, 8'hFF, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
